// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a train of count_in pulses. Each pulse is high for
// PULSE_CYCLES clocks and is followed by a low gap of GAP_CYCLES clocks.
// A one-cycle done strobe follows the trailing gap.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      train request, sampled only in IDLE
//   count_in   number of pulses (0-15), sampled with start
//   abort      (only with PULSE_TRAIN_GEN_ABORT_EN) cancels a running train
//   pulse_out  registered pulse train
//   busy       registered, high in PULSE or GAP
//   done       registered one-cycle completion strobe
//   remaining  registered count of pulses not yet completed
//
// Build option: define PULSE_TRAIN_GEN_ABORT_EN to add the abort input.
//
// state | meaning
// IDLE  | waiting for start
// PULSE | pulse_out high, timer counting down the high time
// GAP   | pulse_out low, timer counting down the low time
// DONE  | one-cycle completion strobe, then back to IDLE
module pulse_train_gen #(
  parameter logic [31:0] PULSE_CYCLES = 32'd5000000,
  parameter logic [31:0] GAP_CYCLES   = 32'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count_in,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic       abort,
`endif
  output logic       pulse_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] remaining
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  remaining_q, remaining_d;
  logic        pulse_out_q, pulse_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // The timer is loaded with (length - 1) on entry; the state ends on the
  // cycle the timer reads zero, so a length of 1 lasts exactly one cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;

    case (state_q)
      IDLE: begin
        timer_d = 32'd0;
        if (start) begin
          if (count_in != 4'd0) begin
            state_d     = PULSE;
            remaining_d = count_in;
            timer_d     = PULSE_CYCLES - 32'd1;
          end else begin
            state_d     = DONE;
            remaining_d = 4'd0;
          end
        end
      end
      PULSE: begin
        if (timer_q == 32'd0) begin
          state_d     = GAP;
          remaining_d = remaining_q - 4'd1;
          timer_d     = GAP_CYCLES - 32'd1;
        end
      end
      GAP: begin
        if (timer_q == 32'd0) begin
          if (remaining_q != 4'd0) begin
            state_d = PULSE;
            timer_d = PULSE_CYCLES - 32'd1;
          end else begin
            state_d = DONE;
            timer_d = 32'd0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        timer_d = 32'd0;
      end
      default: begin
        state_d     = IDLE;
        timer_d     = 32'd0;
        remaining_d = 4'd0;
      end
    endcase

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    // Abort overrides whatever transition was computed above.
    if (abort && ((state_q == PULSE) || (state_q == GAP))) begin
      state_d     = IDLE;
      timer_d     = 32'd0;
      remaining_d = 4'd0;
    end
`endif

    // Outputs are registered copies of the next state so they line up
    // with the state register.
    pulse_out_d = (state_d == PULSE);
    busy_d      = (state_d == PULSE) || (state_d == GAP);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= 32'd0;
      remaining_q <= 4'd0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen with PULSE_CYCLES=3, GAP_CYCLES=2.
// Expected outputs come from an arithmetic model of the train: the sample
// k cycles after the start edge is placed within its (pulse+gap) period.
module tb_pulse_train_gen;

  localparam int P_I = 3;
  localparam int G_I = 2;
  localparam int PER = P_I + G_I;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] count_in;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [3:0] remaining;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic       abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(
    .PULSE_CYCLES(32'd3),
    .GAP_CYCLES  (32'd2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count_in (count_in),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort    (abort),
`endif
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done),
    .remaining(remaining)
  );

  // Expected {pulse_out, busy, done, remaining} k cycles after the start edge.
  function automatic logic [6:0] exp_state(input int n, input int k);
    int total;
    int idx;
    int pos;
    int rem;
    total = n * PER;
    if (k >= 1 && k <= total) begin
      idx = (k - 1) / PER;
      pos = (k - 1) % PER;
      rem = n - idx - ((pos >= P_I) ? 1 : 0);
      return {(pos < P_I), 1'b1, 1'b0, 4'(rem)};
    end else if (k == total + 1) begin
      return {1'b0, 1'b0, 1'b1, 4'd0};
    end
    return 7'd0;
  endfunction

  // Caller is at a negedge with the DUT in IDLE. mode: 0 start for one cycle,
  // 1 start=1/count_in=9 held during the train, 2 random start/count_in
  // during the train, 3 start held high throughout (back-to-back).
  task automatic run_train(input int n, input int mode, input string name);
    int L;
    logic [6:0] act;
    logic [6:0] exp;
    L = (n == 0) ? 1 : n * PER + 1;
    start    = 1'b1;
    count_in = 4'(n);
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      act = {pulse_out, busy, done, remaining};
      exp = exp_state(n, k);
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s n=%0d k=%0d: got pulse/busy/done/rem=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                 name, n, k, act[6], act[5], act[4], act[3:0], exp[6], exp[5], exp[4], exp[3:0]);
      end
      if (k <= L) begin
        case (mode)
          0: start = 1'b0;
          1: begin start = 1'b1; count_in = 4'd9; end
          2: begin start = 1'($urandom); count_in = 4'($urandom); end
          default: ;
        endcase
      end else if (mode != 3) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    count_in = 4'd0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort    = 1'b0;
`endif
    #1;
    n_checks++;
    if ({pulse_out, busy, done, remaining} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b, expected 0000000", {pulse_out, busy, done, remaining});
    end
    repeat (3) @(negedge clk);
    start = 1'b1;
    count_in = 4'd5;
    @(negedge clk);
    n_checks++;
    if ({pulse_out, busy, done, remaining} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b, expected 0000000", {pulse_out, busy, done, remaining});
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_train(3, 0, "basic_n3");
  endtask

  task automatic test_zero();
    run_train(0, 0, "zero_count");
  endtask

  task automatic test_ignore_start();
    run_train(2, 1, "ignore_restart");
  endtask

  task automatic test_back_to_back();
    run_train(1, 3, "b2b_first");
    run_train(1, 0, "b2b_second");
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(0, 15));
      run_train(n, 2, "random");
    end
    run_train(15, 0, "max_count");
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    count_in = 4'd4;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (pulse_out !== 1'b1 || remaining !== 4'd3) begin
      n_fail++;
      $display("FAIL mid_second_pulse: got pulse=%b rem=%0d, expected 1/3", pulse_out, remaining);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pulse_out, busy, done, remaining} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b, expected 0000000", {pulse_out, busy, done, remaining});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_checks++;
      if ({pulse_out, busy, done, remaining} !== 7'd0) begin
        n_fail++;
        $display("FAIL after_reset_quiet k=%0d: got %b, expected 0000000", k, {pulse_out, busy, done, remaining});
      end
    end
  endtask

`ifdef PULSE_TRAIN_GEN_ABORT_EN
  task automatic test_abort();
    logic [6:0] exp;
    start = 1'b1;
    count_in = 4'd5;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp = exp_state(5, k);
      n_checks++;
      if ({pulse_out, busy, done, remaining} !== exp) begin
        n_fail++;
        $display("FAIL abort_pre k=%0d: got %b, expected %b", k, {pulse_out, busy, done, remaining}, exp);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({pulse_out, busy, done, remaining} !== 7'd0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b, expected 0000000", {pulse_out, busy, done, remaining});
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pulse_out !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done k=%0d: got done/busy/pulse=%b/%b/%b, expected 0/0/0", k, done, busy, pulse_out);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_random();
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
